// File: rtl/reg5_arb_pkg.sv
// Shared definitions for the Reg5 write arbiter: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg5_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Winner selection: first asserted req at or after ptr, searching upward modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; vld is simply the OR of all requests.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            vld
);

    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        vld = |req;
        // Walk from the farthest offset down so the closest hit to ptr wins.
        for (int off = NREQ - 1; off >= 0; off--) begin
            j = (int'(ptr) + off) % NREQ;
            if (req[j]) begin
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg5_arb.sv
// Arbitrates NREQ requesters onto one shared Reg5 via a four-phase req/ack handshake.
// Latency: grant latched at the sampling edge, reg_ld for one cycle after it, ack the cycle after that.
// Backpressure: losers are held off until the winner drops req; REG5_ARB_FIXED_PRIO_EN selects fixed priority.
module reg5_arb
    import reg5_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        data,
    output logic [NREQ-1:0]          ack,
    output logic                     reg_ld,
    output logic [W-1:0]             reg_in,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

`ifdef REG5_ARB_FIXED_PRIO_EN
    // Pointer pinned at 0 turns the rotating search into lowest-index-first.
    assign ptr_nxt = '0;
`else
    assign ptr_nxt = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                gnt_id <= pick_idx;
            end
            if (state == ACK) begin
                ptr <= ptr_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        reg_ld    = 1'b0;
        reg_in    = '0;
        ack       = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Gate with rst so a reset landing mid-LOAD can never leak a write strobe.
                reg_ld    = ~rst;
                reg_in    = rst ? '0 : data[int'(gnt_id)*W +: W];
                state_nxt = ACK;
            end
            ACK: begin
                ack[gnt_id] = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (!req[gnt_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg5_arb.sv
// Scoreboard bench for reg5_arb: expected grants are queued at stimulus time and popped on ack.
// Includes a Reg5 model written on reg_ld and checks the reg_ld -> single ack invariant.
module tb_reg5_arb;

    localparam int NREQ = 4;
    localparam int W    = 5;

    typedef struct packed {
        logic [1:0] id;
        logic [4:0] dat;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]   ack;
    logic              reg_ld;
    logic [W-1:0]      reg_in;
    logic [1:0]        gnt_id;
    logic              busy;

    logic [4:0] dv [NREQ];
    logic [4:0] reg_model;
    logic       prev_ld;
    exp_t       sb [$];
    int         n_cmp;
    int         n_bad;

    reg5_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .ack    (ack),
        .reg_ld (reg_ld),
        .reg_in (reg_in),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_dat(input int i, input logic [4:0] v);
        dv[i] = v;
        data[i*W +: W] = v;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id  = 2'(id);
        e.dat = dv[id];
        sb.push_back(e);
    endtask

    task automatic wait_ack(output int id);
        bit got;
        got = 1'b0;
        id  = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
            end
        end
        chk("ack_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        chk("idle_seen", got, 1);
    endtask

    task automatic wait_ld();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (reg_ld) got = 1'b1;
        end
        chk("ld_seen", got, 1);
    endtask

    // Shared Reg5 model
    always @(posedge clk) begin
        if (reg_ld === 1'b1) reg_model <= reg_in;
    end

    // Monitor: every write strobe must be followed by exactly one ack, matched to the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (prev_ld) chk("ld_then_ack", $countones(ack), 1);
            if (reg_ld && sb.size() > 0) chk("sb_reg_in", reg_in, sb[0].dat);
            if (ack != '0) begin
                chk("ack_onehot", $countones(ack), 1);
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_gnt_id", gnt_id, e.id);
                    chk("sb_ack", ack, 4'b0001 << e.id);
                    chk("sb_reg5", reg_model, e.dat);
                end
            end
        end
        prev_ld = reg_ld && !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int id;
        logic [4:0] saved;
        int exp_rot [5];
        int exp_t3 [2];
`ifdef REG5_ARB_FIXED_PRIO_EN
        exp_rot = '{0, 0, 0, 0, 0};
        exp_t3  = '{0, 3};
`else
        exp_rot = '{0, 1, 2, 3, 0};
        exp_t3  = '{3, 0};
`endif
        n_cmp = 0;
        n_bad = 0;
        prev_ld = 1'b0;
        reg_model = '0;
        rst = 1'b1;
        req = '0;
        data = '0;
        set_dat(0, 5'h15);
        set_dat(1, 5'h0A);
        set_dat(2, 5'h1F);
        set_dat(3, 5'h03);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ld", reg_ld, 0);
        chk("rst_in", reg_in, 0);
        chk("rst_ack", ack, 0);
        chk("rst_gnt", gnt_id, 0);
        #1 rst = 1'b0;

        // Single request from requester 0
        req = 4'b0001;
        push(0);
        @(negedge clk);
        chk("t1_ld", reg_ld, 1);
        chk("t1_in", reg_in, 5'h15);
        chk("t1_busy", busy, 1);
        wait_ack(id);
        chk("t1_id", id, 0);
        chk("t1_ld_off", reg_ld, 0);
        req = '0;
        wait_idle();

        // All requesters high, winner drops and re-raises after each round
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push(exp_rot[k]);
        for (int k = 0; k < 5; k++) begin
            wait_ack(id);
            chk("t2_rot", id, exp_rot[k]);
            if (k == 4) begin
                req = '0;
            end else begin
                req[id] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                req[id] = 1'b1;
            end
        end
        wait_idle();

        // Wrap-around from the top requester
        req = 4'b0100;
        push(2);
        wait_ack(id);
        req = '0;
        wait_idle();
        req = 4'b1001;
        push(exp_t3[0]);
        push(exp_t3[1]);
        wait_ack(id);
        chk("t3_first", id, exp_t3[0]);
        req[id] = 1'b0;
        wait_ack(id);
        chk("t3_second", id, exp_t3[1]);
        req = '0;
        wait_idle();

        // Winner keeps req high after ack; loser must wait
        set_dat(1, 5'h11);
        req = 4'b1010;
        push(1);
        push(3);
        wait_ack(id);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_busy", busy, 1);
            chk("t4_no_ack", ack, 0);
            chk("t4_no_ld", reg_ld, 0);
        end
        req[1] = 1'b0;
        wait_ack(id);
        chk("t4_loser", id, 3);
        req = '0;
        wait_idle();

        // Winner drops req during LOAD
        set_dat(0, 5'h0E);
        req = 4'b0001;
        push(0);
        wait_ld();
        req = '0;
        wait_ack(id);
        @(negedge clk);
        chk("t5_wait", busy, 1);
        @(negedge clk);
        chk("t5_idle", busy, 0);

        // Asynchronous reset in the middle of LOAD
        set_dat(2, 5'h0C);
        req = 4'b0100;
        wait_ld();
        saved = reg_model;
        #2 rst = 1'b1;
        #1;
        chk("t6_ld", reg_ld, 0);
        chk("t6_in", reg_in, 0);
        chk("t6_ack", ack, 0);
        chk("t6_busy", busy, 0);
        chk("t6_gnt", gnt_id, 0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("t6_reg_kept", reg_model, saved);
        req = 4'b1001;
        push(0);
        wait_ack(id);
        chk("t6_ptr0", id, 0);
        req = '0;
        wait_idle();

        chk("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
